// File: rtl/adma_tx_stat_pkg.sv
// Shared types and sizing helpers for the ADMA TX status tracker.
package adma_tx_stat_pkg;

  localparam int unsigned DMA_LENGTH_W_DEF = 16;

  typedef struct packed {
    logic                        err;
    logic [DMA_LENGTH_W_DEF-1:0] num_atx;
  } tx_rec_t;

  // Width of a counter that must hold values 0..depth inclusive.
  function automatic int unsigned TX_CNT_W(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count; DEPTH must be a power of 2.
module sync_fifo
  import adma_tx_stat_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic                       full,
  output logic [TX_CNT_W(DEPTH)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = TX_CNT_W(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adma_tx_stat_trk.sv
// TX status tracker: counts ATX starts per TX, matches ATX completions, reports finished TXs.
// Optional watchdog enabled by defining ADMA_TX_STAT_TMO_EN.
module adma_tx_stat_trk
  import adma_tx_stat_pkg::*;
#(
  parameter int unsigned DMA_LENGTH_W = 16,
  parameter int unsigned TX_BUF_DEPTH = 4,
  parameter int unsigned TMO_W        = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              atx_start_vld,
  output logic                              atx_start_rdy,
  input  logic                              atx_start_last,
  input  logic                              atx_done,
  input  logic                              atx_done_err,
  output logic                              tx_done_vld,
  input  logic                              tx_done_rdy,
  output logic [DMA_LENGTH_W-1:0]           tx_done_num_atx,
  output logic                              tx_done_err,
  output logic [TX_CNT_W(TX_BUF_DEPTH)-1:0] tx_tracked,
  output logic                              stat_ovf,
  input  logic [TMO_W-1:0]                  tmo_limit,
  output logic                              tx_tmo
);

  localparam int unsigned CW = TX_CNT_W(TX_BUF_DEPTH);

  typedef struct packed {
    logic                    err;
    logic [DMA_LENGTH_W-1:0] num_atx;
  } rec_t;

  logic [DMA_LENGTH_W-1:0] start_cnt;
  logic [DMA_LENGTH_W-1:0] done_cnt;
  logic [DMA_LENGTH_W-1:0] done_cnt_nxt;
  logic [DMA_LENGTH_W-1:0] rec_head;
  logic                    err_acc;
  logic                    err_nxt;
  logic                    start_hs;
  logic                    rec_push;
  logic                    complete;
  logic                    ovf_hit;
  logic                    rec_empty;
  logic                    rec_full_unused;
  logic                    cmp_empty;
  logic                    cmp_full_unused;
  logic                    cmp_pop;
  logic [CW-1:0]           rec_count;
  logic [CW-1:0]           cmp_count;
  rec_t                    cmp_in;
  rec_t                    cmp_head;

  // Shared occupancy bound: record pushes are gated here, so the completion FIFO can never overflow.
  assign tx_tracked    = rec_count + cmp_count;
  assign atx_start_rdy = (tx_tracked < CW'(TX_BUF_DEPTH));
  assign start_hs      = atx_start_vld & atx_start_rdy;
  assign rec_push      = start_hs & atx_start_last;

  assign done_cnt_nxt = done_cnt + DMA_LENGTH_W'(atx_done);
  assign err_nxt      = err_acc | (atx_done & atx_done_err);
  assign complete     = ~rec_empty & (done_cnt_nxt >= rec_head);
  assign ovf_hit      = ~rec_empty & (done_cnt_nxt > rec_head);
  assign cmp_in       = '{err: err_nxt, num_atx: rec_head};

  assign tx_done_vld     = ~cmp_empty;
  assign cmp_pop         = tx_done_vld & tx_done_rdy;
  assign tx_done_num_atx = cmp_empty ? '0 : cmp_head.num_atx;
  assign tx_done_err     = cmp_empty ? 1'b0 : cmp_head.err;

  sync_fifo #(
    .WIDTH (DMA_LENGTH_W),
    .DEPTH (TX_BUF_DEPTH)
  ) u_rec_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rec_push),
    .push_data (start_cnt + DMA_LENGTH_W'(1)),
    .pop       (complete),
    .pop_data  (rec_head),
    .empty     (rec_empty),
    .full      (rec_full_unused),
    .count     (rec_count)
  );

  sync_fifo #(
    .WIDTH ($bits(rec_t)),
    .DEPTH (TX_BUF_DEPTH)
  ) u_cmp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (complete),
    .push_data (cmp_in),
    .pop       (cmp_pop),
    .pop_data  (cmp_head),
    .empty     (cmp_empty),
    .full      (cmp_full_unused),
    .count     (cmp_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_cnt <= '0;
      done_cnt  <= '0;
      err_acc   <= 1'b0;
      stat_ovf  <= 1'b0;
    end else begin
      if (start_hs) begin
        start_cnt <= atx_start_last ? '0 : start_cnt + DMA_LENGTH_W'(1);
      end
      if (complete) begin
        done_cnt <= '0;
        err_acc  <= 1'b0;
      end else begin
        done_cnt <= done_cnt_nxt;
        err_acc  <= err_nxt;
      end
      if (ovf_hit) stat_ovf <= 1'b1;
    end
  end

`ifdef ADMA_TX_STAT_TMO_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      if (rec_empty || complete) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt != '1) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
      if ((tmo_limit != '0) && (tmo_cnt == tmo_limit)) tmo_q <= 1'b1;
    end
  end

  assign tx_tmo = tmo_q;
`else
  logic tmo_limit_unused;
  assign tmo_limit_unused = ^tmo_limit;
  assign tx_tmo           = 1'b0;
`endif

endmodule

// File: tb/tb_adma_tx_stat_trk.sv
// Directed self-checking bench for adma_tx_stat_trk; expected values are hand-computed.
module tb_adma_tx_stat_trk;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TW    = 16;
`ifdef ADMA_TX_STAT_TMO_EN
  localparam logic TMO_ON = 1'b1;
`else
  localparam logic TMO_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          atx_start_vld;
  logic          atx_start_rdy;
  logic          atx_start_last;
  logic          atx_done;
  logic          atx_done_err;
  logic          tx_done_vld;
  logic          tx_done_rdy;
  logic [DW-1:0] tx_done_num_atx;
  logic          tx_done_err;
  logic [2:0]    tx_tracked;
  logic          stat_ovf;
  logic [TW-1:0] tmo_limit;
  logic          tx_tmo;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  adma_tx_stat_trk #(
    .DMA_LENGTH_W (DW),
    .TX_BUF_DEPTH (DEPTH),
    .TMO_W        (TW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .atx_start_vld   (atx_start_vld),
    .atx_start_rdy   (atx_start_rdy),
    .atx_start_last  (atx_start_last),
    .atx_done        (atx_done),
    .atx_done_err    (atx_done_err),
    .tx_done_vld     (tx_done_vld),
    .tx_done_rdy     (tx_done_rdy),
    .tx_done_num_atx (tx_done_num_atx),
    .tx_done_err     (tx_done_err),
    .tx_tracked      (tx_tracked),
    .stat_ovf        (stat_ovf),
    .tmo_limit       (tmo_limit),
    .tx_tmo          (tx_tmo)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic last);
    atx_start_vld  = 1'b1;
    atx_start_last = last;
    tick();
    atx_start_vld  = 1'b0;
    atx_start_last = 1'b0;
  endtask

  task automatic do_done(input logic err);
    atx_done     = 1'b1;
    atx_done_err = err;
    tick();
    atx_done     = 1'b0;
    atx_done_err = 1'b0;
  endtask

  task automatic do_pop();
    tx_done_rdy = 1'b1;
    tick();
    tx_done_rdy = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rdy"},  32'(atx_start_rdy),   32'd1);
    check_eq({tag, "_vld"},  32'(tx_done_vld),     32'd0);
    check_eq({tag, "_num"},  32'(tx_done_num_atx), 32'd0);
    check_eq({tag, "_err"},  32'(tx_done_err),     32'd0);
    check_eq({tag, "_trk"},  32'(tx_tracked),      32'd0);
    check_eq({tag, "_ovf"},  32'(stat_ovf),        32'd0);
    check_eq({tag, "_tmo"},  32'(tx_tmo),          32'd0);
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #2;
    check_reset_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n          = 1'b1;
    atx_start_vld  = 1'b0;
    atx_start_last = 1'b0;
    atx_done       = 1'b0;
    atx_done_err   = 1'b0;
    tx_done_rdy    = 1'b0;
    tmo_limit      = '0;
    #1;
    pulse_reset("rst");

    // T1: 3-ATX TX, report one cycle after the 3rd done beat
    do_start(1'b0);
    do_start(1'b0);
    do_start(1'b1);
    check_eq("t1_trk", 32'(tx_tracked), 32'd1);
    do_done(1'b0);
    do_done(1'b0);
    check_eq("t1_vld_early", 32'(tx_done_vld), 32'd0);
    do_done(1'b0);
    check_eq("t1_vld", 32'(tx_done_vld),     32'd1);
    check_eq("t1_num", 32'(tx_done_num_atx), 32'd3);
    check_eq("t1_err", 32'(tx_done_err),     32'd0);
    do_pop();
    check_eq("t1_vld_pop", 32'(tx_done_vld), 32'd0);
    check_eq("t1_trk_pop", 32'(tx_tracked),  32'd0);

    // T2: fill tracker with unreported single-ATX TXs
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t2_rdy_%0d", i), 32'(atx_start_rdy), 32'd1);
      do_start(1'b1);
      do_done(1'b0);
    end
    check_eq("t2_rdy_full", 32'(atx_start_rdy), 32'd0);
    check_eq("t2_trk_full", 32'(tx_tracked),    32'd4);
    do_start(1'b1);
    check_eq("t2_trk_blocked", 32'(tx_tracked), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t2_vld_%0d", i), 32'(tx_done_vld),     32'd1);
      check_eq($sformatf("t2_num_%0d", i), 32'(tx_done_num_atx), 32'd1);
      do_pop();
      check_eq($sformatf("t2_trk_%0d", i), 32'(tx_tracked), 32'(3 - i));
      check_eq($sformatf("t2_rdy_pop_%0d", i), 32'(atx_start_rdy), 32'd1);
    end
    check_eq("t2_vld_end", 32'(tx_done_vld), 32'd0);

    // T3: error on the 2nd ATX, then a clean TX
    do_start(1'b0);
    do_start(1'b1);
    do_done(1'b0);
    do_done(1'b1);
    check_eq("t3_num", 32'(tx_done_num_atx), 32'd2);
    check_eq("t3_err", 32'(tx_done_err),     32'd1);
    do_pop();
    do_start(1'b1);
    do_done(1'b0);
    check_eq("t3_num2", 32'(tx_done_num_atx), 32'd1);
    check_eq("t3_err2", 32'(tx_done_err),     32'd0);
    do_pop();

    // T4: done beats arrive before the last start
    do_done(1'b0);
    do_done(1'b0);
    do_start(1'b0);
    check_eq("t4_vld_pre", 32'(tx_done_vld), 32'd0);
    do_start(1'b1);
    check_eq("t4_vld_push", 32'(tx_done_vld), 32'd0);
    tick();
    check_eq("t4_vld", 32'(tx_done_vld),     32'd1);
    check_eq("t4_num", 32'(tx_done_num_atx), 32'd2);
    check_eq("t4_ovf", 32'(stat_ovf),        32'd0);
    do_pop();

    // T5: overflow, then reset mid-TX
    do_done(1'b0);
    do_done(1'b0);
    do_start(1'b1);
    tick();
    check_eq("t5_ovf", 32'(stat_ovf),        32'd1);
    check_eq("t5_vld", 32'(tx_done_vld),     32'd1);
    check_eq("t5_num", 32'(tx_done_num_atx), 32'd1);
    do_pop();
    do_start(1'b0);
    do_start(1'b0);
    pulse_reset("t5_rst");
    do_start(1'b1);
    do_done(1'b0);
    check_eq("t5_post_num", 32'(tx_done_num_atx), 32'd1);
    do_pop();

    // T6: watchdog (stays low when the feature is compiled out)
    tmo_limit = TW'(10);
    do_start(1'b1);
    repeat (10) tick();
    check_eq("t6_tmo_early", 32'(tx_tmo), 32'd0);
    tick();
    check_eq("t6_tmo", 32'(tx_tmo), 32'(TMO_ON));
    do_done(1'b0);
    do_pop();
    check_eq("t6_tmo_sticky", 32'(tx_tmo), 32'(TMO_ON));
    pulse_reset("t6_rst");
    tmo_limit = '0;
    do_start(1'b1);
    repeat (30) tick();
    check_eq("t6_tmo_dis", 32'(tx_tmo), 32'd0);
    do_done(1'b0);
    do_pop();
    check_eq("t6_trk_end", 32'(tx_tracked), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
